// File: rtl/vec_width_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : vec_width_fifo_if
// Purpose  : Bundles the data-path handshake and status signals of
//            vec_width_fifo. The producer/consumer side uses the master
//            modport; the FIFO itself uses the slave modport.
// Signals  : flush                - synchronous clear request
//            wr_valid/ready/data  - write beat handshake, WR_BYTES bytes
//            rd_valid/ready/data  - read beat handshake, RD_BYTES bytes
//            level                - bytes currently stored
//            ovf_err / unf_err    - sticky overflow / underflow flags
// Revision : 1.0 - initial release
// ============================================================================
interface vec_width_fifo_if #(
  parameter int WR_BYTES    = 4,
  parameter int RD_BYTES    = 2,
  parameter int DEPTH_BYTES = 64
);
  logic                               flush;
  logic                               wr_valid;
  logic                               wr_ready;
  logic [WR_BYTES-1:0][7:0]           wr_data;
  logic                               rd_valid;
  logic                               rd_ready;
  logic [RD_BYTES-1:0][7:0]           rd_data;
  logic [$clog2(DEPTH_BYTES+1)-1:0]   level;
  logic                               ovf_err;
  logic                               unf_err;

  modport master (
    output flush, wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, level, ovf_err, unf_err
  );

  modport slave (
    input  flush, wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, level, ovf_err, unf_err
  );
endinterface
`default_nettype wire

// File: rtl/vec_width_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vec_width_fifo
// Purpose  : Byte-granular circular FIFO converting WR_BYTES-wide write beats
//            into RD_BYTES-wide read beats while preserving byte order.
//            Read side is first-word fall-through.
// Ports    : clk_in - clock, all state on rising edge
//            rst_in - asynchronous active-high reset
//            bus    - vec_width_fifo_if.slave (flush, write/read handshakes,
//                     level, sticky ovf_err / unf_err)
// Revision : 1.0 - initial release
// ============================================================================
module vec_width_fifo #(
  parameter int WR_BYTES    = 4,
  parameter int RD_BYTES    = 2,
  parameter int DEPTH_BYTES = 64
) (
  input  wire logic          clk_in,
  input  wire logic          rst_in,
  vec_width_fifo_if.slave    bus
);

  localparam int c_AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int c_LW = $clog2(DEPTH_BYTES + 1);

  localparam logic [c_LW-1:0] c_DEPTH = c_LW'(DEPTH_BYTES);
  localparam logic [c_LW-1:0] c_WR    = c_LW'(WR_BYTES);
  localparam logic [c_LW-1:0] c_RD    = c_LW'(RD_BYTES);

  // Reject geometries the byte-pointer wrap arithmetic cannot support.
  if ((DEPTH_BYTES < 2) ||
      ((DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0) ||
      (WR_BYTES < 1) || (RD_BYTES < 1) ||
      ((DEPTH_BYTES % WR_BYTES) != 0) ||
      ((DEPTH_BYTES % RD_BYTES) != 0)) begin : g_bad_params
    $error("vec_width_fifo: DEPTH_BYTES must be a power of two and a multiple of WR_BYTES and RD_BYTES");
  end

  logic [7:0]      r_mem [DEPTH_BYTES];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_LW-1:0] r_level;
  logic            r_ovf_err;
  logic            r_unf_err;

  logic            w_wr_ready;
  logic            w_rd_valid;
  logic            w_wr_fire;
  logic            w_rd_fire;
  logic [c_LW-1:0] w_level_nxt;

  // Flow control looks only at the registered level: a read in the same
  // cycle never grants write credit, and a write never bypasses to the read.
  assign w_wr_ready = ((c_DEPTH - r_level) >= c_WR);
  assign w_rd_valid = (r_level >= c_RD);
  assign w_wr_fire  = bus.wr_valid & w_wr_ready;
  assign w_rd_fire  = w_rd_valid & bus.rd_ready;

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr_fire) w_level_nxt = w_level_nxt + c_WR;
    if (w_rd_fire) w_level_nxt = w_level_nxt - c_RD;
  end

  // Pointers wrap for free because DEPTH_BYTES is a power of two.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else begin
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + c_AW'(WR_BYTES);
      if (w_rd_fire) r_rd_ptr <= r_rd_ptr + c_AW'(RD_BYTES);
      r_level <= w_level_nxt;
      if (bus.wr_valid & ~w_wr_ready) r_ovf_err <= 1'b1;
      if (bus.rd_ready & ~w_rd_valid) r_unf_err <= 1'b1;
    end
  end

  // Storage has no reset; stale bytes are unreachable once pointers clear.
  always_ff @(posedge clk_in) begin
    if (w_wr_fire && !bus.flush) begin
      for (int k = 0; k < WR_BYTES; k++) begin
        r_mem[r_wr_ptr + c_AW'(k)] <= bus.wr_data[k];
      end
    end
  end

  for (genvar k = 0; k < RD_BYTES; k++) begin : g_rd_bytes
    assign bus.rd_data[k] = r_mem[r_rd_ptr + c_AW'(k)];
  end

  assign bus.wr_ready = w_wr_ready;
  assign bus.rd_valid = w_rd_valid;
  assign bus.level    = r_level;
  assign bus.ovf_err  = r_ovf_err;
  assign bus.unf_err  = r_unf_err;

endmodule
`default_nettype wire

// File: tb/tb_vec_width_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_width_fifo
// Purpose  : Directed self-checking bench for vec_width_fifo with
//            WR_BYTES=4, RD_BYTES=2, DEPTH_BYTES=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_width_fifo;
  localparam int WR_BYTES    = 4;
  localparam int RD_BYTES    = 2;
  localparam int DEPTH_BYTES = 16;

  logic clk_in = 1'b0;
  logic rst_in;

  always #5 clk_in = ~clk_in;

  vec_width_fifo_if #(
    .WR_BYTES(WR_BYTES), .RD_BYTES(RD_BYTES), .DEPTH_BYTES(DEPTH_BYTES)
  ) bus ();

  vec_width_fifo #(
    .WR_BYTES(WR_BYTES), .RD_BYTES(RD_BYTES), .DEPTH_BYTES(DEPTH_BYTES)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic write_beat(input logic [31:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic read_beat();
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [15:0] e16;
    int sent;
    int cyc;

    rst_in       = 1'b1;
    bus.flush    = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    #3;
    // Reset state, before any clock edge
    check("rst_level",    32'(bus.level),    32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_ovf",      32'(bus.ovf_err),  32'd0);
    check("rst_unf",      32'(bus.unf_err),  32'd0);
    tick();
    rst_in = 1'b0;
    tick();

    // Single write, two reads, byte order 0x00,0x01 then 0x02,0x03
    write_beat(32'h0302_0100);
    check("w1_level",    32'(bus.level),    32'd4);
    check("w1_rd_valid", 32'(bus.rd_valid), 32'd1);
    check("w1_rd_data",  32'(bus.rd_data),  32'h0100);
    read_beat();
    check("r1_rd_data",  32'(bus.rd_data),  32'h0302);
    check("r1_level",    32'(bus.level),    32'd2);
    read_beat();
    check("r2_level",    32'(bus.level),    32'd0);
    check("r2_rd_valid", 32'(bus.rd_valid), 32'd0);

    // Fill to capacity; stream bytes 0x10..0x1F
    for (int i = 0; i < 4; i++) begin
      d = {8'(8'h13 + 4*i), 8'(8'h12 + 4*i), 8'(8'h11 + 4*i), 8'(8'h10 + 4*i)};
      write_beat(d);
    end
    check("full_level",    32'(bus.level),    32'd16);
    check("full_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("full_ovf_pre",  32'(bus.ovf_err),  32'd0);
    write_beat(32'hEEEE_EEEE);
    check("ovf_level",     32'(bus.level),    32'd16);
    check("ovf_flag",      32'(bus.ovf_err),  32'd1);
    check("ovf_rd_data",   32'(bus.rd_data),  32'h1110);

    // Full with both sides requesting: only the read fires
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hDDDD_DDDD;
    bus.rd_ready = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    check("full_rw_level", 32'(bus.level), 32'd14);
    for (int j = 1; j < 8; j++) begin
      e16 = {8'(8'h11 + 2*j), 8'(8'h10 + 2*j)};
      check("drain_data", 32'(bus.rd_data), 32'(e16));
      read_beat();
    end
    check("drain_level", 32'(bus.level),   32'd0);
    check("drain_ovf",   32'(bus.ovf_err), 32'd1);
    do_flush();
    check("flush_ovf",   32'(bus.ovf_err), 32'd0);

    // Simultaneous write and read at level 12
    for (int i = 0; i < 3; i++) write_beat(32'h2322_2120 + 32'h0404_0404 * i);
    check("l12_level", 32'(bus.level), 32'd12);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h2F2E_2D2C;
    bus.rd_ready = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    check("l12_rw_level", 32'(bus.level),   32'd14);
    check("l12_rw_data",  32'(bus.rd_data), 32'h2322);
    do_flush();

    // Streaming: 40 random write beats with reads whenever data is available
    sent = 0;
    cyc  = 0;
    exp_q.delete();
    while ((sent < 40 || bus.level != 0) && cyc < 600) begin
      bus.wr_valid = (sent < 40) && bus.wr_ready;
      bus.rd_ready = bus.rd_valid;
      if (bus.rd_valid) begin
        if (exp_q.size() >= 2) begin
          e16 = {exp_q[1], exp_q[0]};
          check("stream_data", 32'(bus.rd_data), 32'(e16));
          void'(exp_q.pop_front());
          void'(exp_q.pop_front());
        end else begin
          check("stream_extra_beat", 32'(exp_q.size()), 32'd2);
        end
      end
      if (bus.wr_valid) begin
        d = $urandom;
        bus.wr_data = d;
        for (int k = 0; k < WR_BYTES; k++) exp_q.push_back(d[8*k +: 8]);
        sent++;
      end
      tick();
      cyc++;
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    check("stream_in_time", 32'(cyc < 600),      32'd1);
    check("stream_sent",    32'(sent),           32'd40);
    check("stream_left",    32'(exp_q.size()),   32'd0);
    check("stream_ovf",     32'(bus.ovf_err),    32'd0);
    check("stream_unf",     32'(bus.unf_err),    32'd0);

    // Read requested while empty, with a concurrent write
    do_flush();
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h3332_3130;
    bus.rd_ready = 1'b1;
    tick();
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    check("unf_flag",    32'(bus.unf_err), 32'd1);
    check("unf_level",   32'(bus.level),   32'd4);
    check("unf_rd_data", 32'(bus.rd_data), 32'h3130);

    // Asynchronous reset mid-cycle at level 10
    do_flush();
    for (int i = 0; i < 3; i++) write_beat(32'h4342_4140 + 32'h0404_0404 * i);
    read_beat();
    check("pre_rst_level", 32'(bus.level), 32'd10);
    #2;
    rst_in = 1'b1;
    #1;
    check("arst_level",    32'(bus.level),    32'd0);
    check("arst_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("arst_rd_valid", 32'(bus.rd_valid), 32'd0);
    #1;
    rst_in = 1'b0;
    tick();

    // Underflow while empty, then first beat after reset lands at address 0
    read_beat();
    check("empty_unf",       32'(bus.unf_err), 32'd1);
    check("empty_unf_level", 32'(bus.level),   32'd0);
    write_beat(32'hA3A2_A1A0);
    check("post_rst_data", 32'(bus.rd_data), 32'hA1A0);
    write_beat(32'hA7A6_A5A4);
    check("pre_flush_level", 32'(bus.level), 32'd8);

    // Flush wins over a concurrent write and clears the sticky flags
    bus.flush    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hB3B2_B1B0;
    tick();
    bus.flush    = 1'b0;
    bus.wr_valid = 1'b0;
    check("flush_level",    32'(bus.level),    32'd0);
    check("flush_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("flush_unf",      32'(bus.unf_err),  32'd0);
    check("flush_ovf2",     32'(bus.ovf_err),  32'd0);
    check("flush_wr_ready", 32'(bus.wr_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
